ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage of the RV32I core: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers fetched words in a 2-entry queue. The queue head drives the decoder and immediate generator through `o_inst`/`o_pc`. Branch/jump redirects from execute flush the queue and restart fetch at the target.

## Interface
- `RESET_VEC`, default 32'h0000_0000: PC after reset.
- `i_clk` in 1: clock, all state on rising edge.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_redirect` in 1: taken branch/JAL/JALR this cycle.
- `i_redirect_pc` in 32: redirect target.
- `i_stall` in 1: downstream cannot consume the head this cycle.
- `o_imem_req` out 1: memory read request.
- `o_imem_addr` out 32: word address of the request.
- `i_imem_ack` in 1: read complete; `i_imem_rdata` valid this cycle; may assert in the same cycle as `o_imem_req`.
- `i_imem_rdata` in 32: instruction word.
- `o_inst` out 32: queue-head instruction.
- `o_pc` out 32: PC of `o_inst`.
- `o_inst_vld` out 1: queue non-empty.
- `o_misalign` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- State: `pc_q` (next fetch address), `drain_addr_q`, FIFO of {pc, inst} with depth 2, `count_q` 0..2, FSM {RUN, WAIT, DRAIN, HALT}.
- `can_issue` = `count_q` < 2 (registered count, no pop look-ahead).
- `o_imem_req` = (RUN & `can_issue`) | WAIT | DRAIN. `o_imem_addr` = `drain_addr_q` in DRAIN, else `pc_q`.
- Handshake: once `o_imem_req` is high without ack, req and addr hold stable until ack. At most one request outstanding.
- RUN: req & ack -> push {`pc_q`, rdata}, `pc_q` += 4, stay RUN. req & !ack -> WAIT.
- WAIT: ack -> push, `pc_q` += 4, -> RUN.
- DRAIN: ack -> response discarded, -> RUN.
- HALT: no requests. Only reset exits.
- Pop: `o_inst_vld` & !`i_stall`. Push and pop in the same cycle leave `count_q` unchanged. A push never occurs at `count_q` = 2.
- Redirect has priority over everything and applies in any state except HALT:
  - `count_q` <= 0.
  - `pc_q` <= target.
  - No push this cycle; a same-cycle ack is discarded.
  - If a request is in flight and not acked this cycle (RUN with req & !ack, or WAIT with !ack): `drain_addr_q` <= current `o_imem_addr`, -> DRAIN. Otherwise -> RUN.
  - A redirect while in DRAIN updates `pc_q` and stays in DRAIN.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - `pc_q` = `RESET_VEC`, `count_q` = 0, state RUN, `o_misalign` = 0.
  - `o_inst_vld` = 0, `o_inst` = 32'h0000_0013 (NOP), `o_pc` = `RESET_VEC`.
  - `o_imem_req` = 0 while `i_rst` is high; `o_imem_addr` = `RESET_VEC`.
- First request: the first cycle after `i_rst` deasserts.
- Latency: with a same-cycle ack, a word is visible on `o_inst` one cycle after the request. Throughput is one instruction per cycle when `i_stall` is low.
- `o_inst`/`o_pc` hold stable while `i_stall` is high.
- Reset mid-request: the transaction is abandoned and the memory must tolerate the dropped req.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `i_redirect_pc[1:0]` != 0 flushes the queue as a normal redirect and sets `o_misalign` (sticky until reset).
  - The FSM goes to DRAIN if a request is in flight, else HALT; DRAIN completes into HALT when `o_misalign` is set.
  - In HALT, `o_inst_vld` = 0.
- Undefined:
  - `i_redirect_pc[1:0]` is forced to 0 before use.
  - `o_misalign` is tied 0 and HALT is unreachable.

## Test plan
- Reset with `RESET_VEC` = 32'h100, memory acks same cycle -> addrs 0x100, 0x104, 0x108 on consecutive cycles; `o_pc` follows one cycle later with `o_inst_vld` = 1.
- Memory acks 3 cycles after req -> req/addr stable through the wait; one word delivered per 4 cycles.
- `i_stall` high for 5 cycles -> `count_q` reaches 2, req drops, `o_inst`/`o_pc` frozen; release -> in-order delivery with no loss or duplication.
- Redirect to 0x200 in WAIT (addr 0x10C outstanding) -> DRAIN holds 0x10C until ack, data discarded; next req to 0x200; first `o_pc` = 0x200.
- `pc_q` = 32'hFFFF_FFFC fetch -> next addr 0x0.
- Redirect to 0x202: with `IFETCH_MISALIGN_TRAP_EN`, `o_misalign` = 1, HALT, no further req. Without the macro, fetch resumes at 0x200.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch: PC, req/ack instruction-memory port, 2-entry {pc, inst} queue, redirect flush.
// Optional feature: define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirects into HALT.
module ifetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_inst_vld,
    output logic        o_misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [1:0]  count_q, count_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_inst [2];
    logic        rd_ptr_q, wr_ptr_q;

    logic        can_issue;
    logic        redir_take;
    logic        push;
    logic        pop;
    logic        bad_target;
    logic [31:0] target;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign target     = i_redirect_pc;
    assign bad_target = (i_redirect_pc[1:0] != 2'b00);
`else
    assign target     = i_redirect_pc & 32'hFFFF_FFFC;
    assign bad_target = 1'b0;
`endif

    assign can_issue  = (count_q < 2'd2);
    assign redir_take = i_redirect && (state_q != HALT);
    assign o_inst_vld = (count_q != 2'd0) && (state_q != HALT);
    assign pop        = o_inst_vld && !i_stall;
    assign o_inst     = fifo_inst[rd_ptr_q];
    assign o_pc       = fifo_pc[rd_ptr_q];
    assign o_misalign = misalign_q;

    always_comb begin
        o_imem_req = 1'b0;
        if (!i_rst) begin
            case (state_q)
                RUN:     o_imem_req = can_issue;
                WAIT:    o_imem_req = 1'b1;
                DRAIN:   o_imem_req = 1'b1;
                default: o_imem_req = 1'b0;
            endcase
        end
        o_imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    end

    // Next-state logic; a redirect overrides every other action and drops any same-cycle ack.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        misalign_d   = misalign_q;
        push         = 1'b0;
        count_d      = count_q;

        if (redir_take) begin
            count_d    = 2'd0;
            pc_d       = target;
            misalign_d = misalign_q | bad_target;
            if (o_imem_req && !i_imem_ack) begin
                drain_addr_d = o_imem_addr;
                state_d      = DRAIN;
            end else begin
                state_d = (misalign_q | bad_target) ? HALT : RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (o_imem_req && i_imem_ack) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else if (o_imem_req) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (i_imem_ack) begin
                        push    = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (i_imem_ack) begin
                        state_d = misalign_q ? HALT : RUN;
                    end
                end
                default: state_d = HALT;
            endcase
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_VEC;
            drain_addr_q <= RESET_VEC;
            count_q      <= 2'd0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            misalign_q   <= misalign_d;
        end
    end

    // Queue storage; a flush just rewinds both pointers, stale entries are never exposed as valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]   <= RESET_VEC;
                fifo_inst[i] <= NOP;
            end
        end else if (redir_take) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr_q]   <= pc_q;
                fifo_inst[wr_ptr_q] <= i_imem_rdata;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: random memory latency, stalls and redirects checked against
// an expected instruction-stream model.
module tb_ifetch;

    localparam logic [31:0] RV = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_vld;
    logic        misalign;

    int          total = 0;
    int          bad = 0;
    int          lat_mode = 0;
    int          ack_count = 0;
    int          wcnt = 0;
    int          cur_lat = 0;

    entry_t      expq[$];
    entry_t      e;
    logic [31:0] next_pc = RV;
    bit          halted = 1'b0;

    ifetch #(.RESET_VEC(RV)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_redirect(redirect),
        .i_redirect_pc(redirect_pc),
        .i_stall(stall),
        .o_imem_req(imem_req),
        .o_imem_addr(imem_addr),
        .i_imem_ack(ack),
        .i_imem_rdata(rdata),
        .o_inst(inst),
        .o_pc(pc),
        .o_inst_vld(inst_vld),
        .o_misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] tgt, input logic stl);
        redirect    = redir;
        redirect_pc = tgt;
        stall       = stl;
    endtask

    // Expected stream: consecutive words from the latest redirect target.
    function automatic void modelRedirect(input logic [31:0] t);
        expq.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) halted = 1'b1;
        next_pc = t;
`else
        next_pc = t & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic void refill();
        while (!halted && expq.size() < 8) begin
            expq.push_back('{pc: next_pc, inst: memword(next_pc)});
            next_pc = next_pc + 32'd4;
        end
    endfunction

    // Memory: decides ack for the current cycle after the DUT's request has settled.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                ack  = 1'b0;
                wcnt = 0;
            end else if (imem_req) begin
                if (wcnt == 0) cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                if (wcnt >= cur_lat) begin
                    ack   = 1'b1;
                    rdata = memword(imem_addr);
                    wcnt  = 0;
                    ack_count++;
                end else begin
                    ack   = 1'b0;
                    rdata = $urandom;
                    wcnt++;
                end
            end else begin
                ack  = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: scoreboard pops plus handshake-hold and stall-freeze properties.
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_inst = '0;
    logic [31:0] prev_pc = '0;

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_pend = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (prev_pend) begin
                    checkOutput("req_hold", {31'b0, imem_req}, 32'd1);
                    checkOutput("addr_hold", imem_addr, prev_addr);
                end
                if (prev_hold) begin
                    checkOutput("inst_frozen", inst, prev_inst);
                    checkOutput("pc_frozen", pc, prev_pc);
                end
                if (inst_vld && !stall) begin
                    refill();
                    total++;
                    if (expq.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_pop: got pc %h expected no valid output", pc);
                    end else begin
                        e = expq.pop_front();
                        if (pc !== e.pc || inst !== e.inst) begin
                            bad++;
                            $display("[TB] FAIL pop: got pc %h inst %h expected pc %h inst %h",
                                     pc, inst, e.pc, e.inst);
                        end
                    end
                end
                if (redirect) modelRedirect(redirect_pc);
                prev_pend = imem_req && !ack;
                prev_addr = imem_addr;
                prev_hold = inst_vld && stall && !redirect;
                prev_inst = inst;
                prev_pc   = pc;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] held_addr;
        bit          found;

        applyStimulus(1'b0, 32'h0, 1'b0);
        lat_mode = 0;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_addr", imem_addr, RV);
        checkOutput("rst_vld", {31'b0, inst_vld}, 32'd0);
        checkOutput("rst_inst", inst, 32'h0000_0013);
        checkOutput("rst_pc", pc, RV);
        checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);

        // Same-cycle ack: back-to-back addresses, o_pc one cycle behind.
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("first_req", {31'b0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, RV);
        checkOutput("first_vld", {31'b0, inst_vld}, 32'd0);
        @(negedge clk);
        #2;
        checkOutput("addr1", imem_addr, RV + 32'd4);
        checkOutput("vld1", {31'b0, inst_vld}, 32'd1);
        checkOutput("pc1", pc, RV);
        @(negedge clk);
        #2;
        checkOutput("addr2", imem_addr, RV + 32'd8);
        checkOutput("pc2", pc, RV + 32'd4);

        // Stall fills the queue and request drops.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        #2;
        checkOutput("stall_req", {31'b0, imem_req}, 32'd0);
        checkOutput("stall_vld", {31'b0, inst_vld}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b0);
        end

        // Three-cycle memory: one word per four cycles.
        lat_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (ack) found = 1'b1;
        end
        checkOutput("lat_ack_seen", {31'b0, found}, 32'd1);
        ack_count = 0;
        repeat (40) @(negedge clk);
        #2;
        checkOutput("lat_ack_count", ack_count, 32'd10);

        // Redirect while a request waits: drain it, then fetch at the target.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (imem_req && !ack) found = 1'b1;
        end
        checkOutput("wait_seen", {31'b0, found}, 32'd1);
        held_addr = imem_addr;
        applyStimulus(1'b1, 32'h0000_0200, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #2;
            if (imem_req && imem_addr != held_addr) begin
                found = 1'b1;
                checkOutput("redirect_addr", imem_addr, 32'h0000_0200);
            end
            @(negedge clk);
        end
        checkOutput("redirect_seen", {31'b0, found}, 32'd1);

        // Random traffic.
        lat_mode = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 19) == 0,
                          32'h0000_1000 + (32'($urandom_range(0, 255)) << 2),
                          $urandom_range(0, 3) == 0);
        end

        // Address wrap.
        lat_mode = 0;
        @(negedge clk);
        applyStimulus(1'b1, 32'hFFFF_FFF0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #2;
            if (inst_vld && pc == 32'h0) found = 1'b1;
            @(negedge clk);
        end
        checkOutput("wrap_seen", {31'b0, found}, 32'd1);

        // Misaligned redirect.
        applyStimulus(1'b1, 32'h0000_0202, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        repeat (10) @(negedge clk);
        #2;
        checkOutput("trap_misalign", {31'b0, misalign}, 32'd1);
        checkOutput("trap_req", {31'b0, imem_req}, 32'd0);
        checkOutput("trap_vld", {31'b0, inst_vld}, 32'd0);
`else
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #2;
            if (inst_vld) begin
                found = 1'b1;
                checkOutput("misalign_pc", pc, 32'h0000_0200);
            end
            @(negedge clk);
        end
        checkOutput("misalign_seen", {31'b0, found}, 32'd1);
        checkOutput("misalign_flag", {31'b0, misalign}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
